// File: rtl/timer_interface.sv
// Memory-mapped down-counting timer: prescaled tick, one-shot or periodic reload,
// sticky expiry flag cleared by control write (bit31) or by the first cycle of a status read.
module timer_interface #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic        reload_cs,
  input  logic        control_cs,
  input  logic        status_cs,
  input  logic        count_cs,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  output logic        expired
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PreMax = PW'(PRESCALE - 1);

  logic [31:0]   count_q, count_d;
  logic [31:0]   reload_q, reload_d;
  logic          enable_q, enable_d;
  logic          periodic_q, periodic_d;
  logic          expired_q, expired_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic          status_rd_q;

  logic reload_wr, control_wr, status_rd, tick, expire;

  assign reload_wr  = write & reload_cs;
  assign control_wr = write & control_cs;
  assign status_rd  = read & status_cs;
  assign tick       = enable_q && (prescaler_q == PreMax);
  assign expired    = expired_q;

  always_comb begin
    count_d     = count_q;
    reload_d    = reload_q;
    enable_d    = enable_q;
    periodic_d  = periodic_q;
    expired_d   = expired_q;
    prescaler_d = prescaler_q;
    expire      = 1'b0;

    if (enable_q) begin
      prescaler_d = tick ? '0 : prescaler_q + PW'(1);
    end

    // A reload write on the tick edge discards the tick entirely.
    if (tick && !reload_wr) begin
      if (count_q > 32'd1) begin
        count_d = count_q - 32'd1;
      end else begin
        expire  = 1'b1;
        count_d = periodic_q ? reload_q : '0;
        if (!periodic_q) begin
          enable_d = 1'b0;
        end
      end
    end

    if (control_wr) begin
      enable_d   = data_in[0];
      periodic_d = data_in[1];
      if (!enable_q && data_in[0]) begin
        prescaler_d = '0;
      end
      if (data_in[31]) begin
        expired_d = 1'b0;
      end
    end

    if (reload_wr) begin
      reload_d    = data_in;
      count_d     = data_in;
      prescaler_d = '0;
    end

    // Only the first cycle of a held status read clears the flag.
    if (status_rd && !status_rd_q) begin
      expired_d = 1'b0;
    end

    if (expire) begin
      expired_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q     <= '0;
      reload_q    <= '0;
      enable_q    <= 1'b0;
      periodic_q  <= 1'b0;
      expired_q   <= 1'b0;
      prescaler_q <= '0;
      status_rd_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      reload_q    <= reload_d;
      enable_q    <= enable_d;
      periodic_q  <= periodic_d;
      expired_q   <= expired_d;
      prescaler_q <= prescaler_d;
      status_rd_q <= status_rd;
    end
  end

  always_comb begin
    data_out       = '0;
    data_out_valid = read & (reload_cs | control_cs | status_cs | count_cs);
    if (read) begin
      if (reload_cs) begin
        data_out = reload_q;
      end else if (control_cs) begin
        data_out = {30'b0, periodic_q, enable_q};
      end else if (status_cs) begin
        data_out = {30'b0, enable_q, expired_q};
      end else if (count_cs) begin
        data_out = count_q;
      end
    end
  end

endmodule

// File: tb/tb_timer_interface.sv
// Bench for timer_interface: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a behavioural model of the timer.
module tb_timer_interface;

  localparam int unsigned P = 4;

  logic        clock = 1'b0;
  logic        reset, read, write, reload_cs, control_cs, status_cs, count_cs;
  logic [31:0] data_in, data_out;
  logic        data_out_valid, expired;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  timer_interface #(.PRESCALE(P)) dut (
    .clock          (clock),
    .reset          (reset),
    .read           (read),
    .write          (write),
    .reload_cs      (reload_cs),
    .control_cs     (control_cs),
    .status_cs      (status_cs),
    .count_cs       (count_cs),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .expired        (expired)
  );

  always #5 clock = ~clock;

  // Model: 'elapsed' counts enabled cycles since the last prescaler restart;
  // a tick lands on every P-th such cycle.
  typedef struct {
    logic [31:0] count;
    logic [31:0] reload;
    logic        en;
    logic        per;
    logic        exp;
    logic        prev_rd;
    int unsigned elapsed;
  } model_t;

  model_t m;

  function automatic model_t step(model_t s, logic rst, logic rd, logic wr, logic rl,
                                  logic ct, logic st, logic [31:0] d);
    model_t n;
    bit tick, expire, rd_status;
    n = s;
    if (rst) begin
      n.count = 0; n.reload = 0; n.en = 0; n.per = 0; n.exp = 0; n.prev_rd = 0;
      n.elapsed = 0;
      return n;
    end
    rd_status = rd && st;
    tick      = s.en && ((s.elapsed % P) == P - 1) && !(wr && rl);
    expire    = 0;
    if (s.en) n.elapsed = s.elapsed + 1;
    if (tick) begin
      if (s.count > 1) n.count = s.count - 1;
      else begin
        expire  = 1;
        n.count = s.per ? s.reload : 32'd0;
        if (!s.per) n.en = 0;
      end
    end
    if (wr && ct) begin
      n.en  = d[0];
      n.per = d[1];
      if (!s.en && d[0]) n.elapsed = 0;
      if (d[31]) n.exp = 0;
    end
    if (wr && rl) begin
      n.reload  = d;
      n.count   = d;
      n.elapsed = 0;
    end
    if (rd_status && !s.prev_rd) n.exp = 0;
    if (expire) n.exp = 1;
    n.prev_rd = rd_status;
    return n;
  endfunction

  function automatic logic [32:0] exp_out(model_t s, logic rd, logic rl, logic ct,
                                          logic st, logic cn);
    logic [31:0] d;
    logic        v;
    v = rd && (rl || ct || st || cn);
    d = 0;
    if (v) begin
      if (rl) d = s.reload;
      else if (ct) d = {30'b0, s.per, s.en};
      else if (st) d = {30'b0, s.en, s.exp};
      else d = s.count;
    end
    return {v, d};
  endfunction

  always @(posedge clock) begin
    m <= step(m, reset, read, write, reload_cs, control_cs, status_cs, data_in);
  end

  always @(negedge clock) begin
    logic [32:0] e;
    if (chk_on) begin
      e = exp_out(m, read, reload_cs, control_cs, status_cs, count_cs);
      n_cmp++;
      if ({data_out_valid, data_out} !== e || expired !== m.exp) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t: got valid=%b data=%h expired=%b, need valid=%b data=%h expired=%b",
                 $time, data_out_valid, data_out, expired, e[32], e[31:0], m.exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cs(input int sel);
    reload_cs  = (sel == 0);
    control_cs = (sel == 1);
    status_cs  = (sel == 2);
    count_cs   = (sel == 3);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Combinational read between edges, so it never clears the flag.
  task automatic pchk(input string name, input int sel, input logic [31:0] want);
    read = 1; set_cs(sel);
    #1;
    check(name, data_out, want);
    read = 0; set_cs(-1);
  endtask

  task automatic wr(input int sel, input logic [31:0] d);
    write = 1; set_cs(sel); data_in = d;
    cyc();
    write = 0; set_cs(-1); data_in = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  initial begin
    reset = 1; read = 0; write = 0; data_in = 0; set_cs(-1);
    cyc(); cyc();
    reset = 0;
    chk_on = 1;

    check("rst_valid", {31'b0, data_out_valid}, 0);
    check("rst_data", data_out, 0);
    check("rst_expired", {31'b0, expired}, 0);
    pchk("rst_count", 3, 0);

    // One-shot: reload 3, expiry 12 cycles after the enable write.
    wr(0, 3); wr(1, 1);
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (i == 11) check("t1_not_yet", {31'b0, expired}, 0);
    end
    check("t1_expired", {31'b0, expired}, 1);
    pchk("t1_ctrl", 1, 0);
    pchk("t1_count", 3, 0);
    pchk("t1_status", 2, 1);

    // Periodic reload 2: expiries at 8 and 16; status read clears.
    do_reset();
    wr(0, 2); wr(1, 3);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 7) check("t2_not_yet", {31'b0, expired}, 0);
    end
    check("t2_exp8", {31'b0, expired}, 1);
    read = 1; set_cs(2);
    #1;
    check("t2_status3", data_out, 3);
    cyc();
    read = 0; set_cs(-1);
    cyc();
    pchk("t2_status2", 2, 2);
    for (int j = 11; j <= 16; j++) begin
      cyc();
      if (j == 15) check("t2_not_yet16", {31'b0, expired}, 0);
    end
    check("t2_exp16", {31'b0, expired}, 1);

    // Held status read across an expiry edge; then a new read; then bit31 clear.
    do_reset();
    wr(0, 1); wr(1, 3);
    repeat (7) cyc();
    check("t3_pre", {31'b0, expired}, 1);
    read = 1; set_cs(2);
    cyc();
    check("t3_setwins", {31'b0, expired}, 1);
    cyc(); cyc();
    check("t3_held", {31'b0, expired}, 1);
    read = 0; set_cs(-1);
    cyc(); cyc();
    read = 1; set_cs(2);
    cyc();
    read = 0; set_cs(-1);
    check("t3_newread", {31'b0, expired}, 0);
    repeat (3) cyc();
    check("t3_exp16", {31'b0, expired}, 1);
    wr(1, 32'h8000_0003);
    check("t3_bit31", {31'b0, expired}, 0);

    // Reload write on a tick edge; disable freezes; re-enable restarts prescaler.
    do_reset();
    wr(0, 5); wr(1, 1);
    repeat (7) cyc();
    pchk("t4_pre", 3, 4);
    wr(0, 9);
    pchk("t4_reload", 3, 9);
    repeat (3) cyc();
    pchk("t4_hold", 3, 9);
    cyc();
    pchk("t4_tick", 3, 8);
    wr(1, 0);
    repeat (10) cyc();
    pchk("t4_frozen", 3, 8);
    wr(1, 1);
    repeat (3) cyc();
    pchk("t4_restart_pre", 3, 8);
    cyc();
    pchk("t4_restart_tick", 3, 7);
    check("t4_no_exp", {31'b0, expired}, 0);

    // Reset mid-count with expired set.
    do_reset();
    wr(0, 1); wr(1, 3);
    repeat (5) cyc();
    check("t5_pre", {31'b0, expired}, 1);
    reset = 1;
    cyc();
    reset = 0;
    check("t5_expired", {31'b0, expired}, 0);
    read = 1;
    #1;
    check("t5_valid_nocs", {31'b0, data_out_valid}, 0);
    check("t5_data_nocs", data_out, 0);
    read = 0;
    pchk("t5_reload", 0, 0);
    pchk("t5_ctrl", 1, 0);
    pchk("t5_status", 2, 0);
    pchk("t5_count", 3, 0);
    repeat (10) cyc();
    pchk("t5_count_idle", 3, 0);

    // Randomized traffic, checked by the model process only.
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      int r;
      r = $urandom_range(0, 199);
      read = 0; write = 0; set_cs(-1); data_in = $urandom; reset = 0;
      if (r < 2) reset = 1;
      else if (r < 18) begin
        write = 1; set_cs(0);
        data_in = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 4);
      end else if (r < 30) begin
        write = 1; set_cs(1);
        data_in = ($urandom & 32'h8000_0002) | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
      end else if (r < 90) begin
        read = 1; set_cs($urandom_range(0, 3));
      end else if (r < 100) begin
        read = 1;
      end
      cyc();
    end
    read = 0; write = 0; set_cs(-1); reset = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
